mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory stage directly downstream of the execute stage; owns the EX/MEM and MEM/WB pipeline registers.
//  Latches ALU result, store data, destination register and control from EX.
//  Performs load/store through a req/ack data-memory port and stalls upstream while an access is pending.
//  Drives the MEM and WB forwarding values consumed by the EX operand/store-data muxes.
// PARAMETERS
//  DATA_W   32   datapath and memory word width
//  REG_W    5    register index width
//  TIMEOUT  255  max BUSY cycles awaiting dmem_ack before abort (>=1)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  ex_valid       in   1       EX holds a real instruction
//  ex_alu_out     in   DATA_W  ALU result; load/store address
//  ex_st_data     in   DATA_W  forwarded store data
//  ex_dest        in   REG_W   destination register
//  ex_mem_r       in   1       load
//  ex_mem_w       in   1       store
//  ex_wb_en       in   1       instruction writes register file
//  stall          out  1       hold EX and all earlier stages this cycle
//  dmem_req       out  1       memory request
//  dmem_we        out  1       1 = write, 0 = read
//  dmem_addr      out  DATA_W  address = em ALU result
//  dmem_wdata     out  DATA_W  store data
//  dmem_rdata     in   DATA_W  read data, valid with dmem_ack
//  dmem_ack       in   1       access complete (same cycle as req allowed)
//  fwd_mem_data   out  DATA_W  EX/MEM ALU result (EX "MEM" forward input)
//  fwd_mem_dest   out  REG_W   EX/MEM destination
//  fwd_mem_wb_en  out  1       em_valid & em_wb_en & !em_mem_r
//  wb_valid       out  1       MEM/WB holds a real instruction
//  wb_data        out  DATA_W  write-back value (EX "WB" forward input)
//  wb_dest        out  REG_W   write-back destination
//  wb_en          out  1       register-file write enable
//  mem_err        out  1       sticky: an access timed out
// BEHAVIOUR
//  - Reset (rst=0, async): every register, output and counter clears to 0; FSM->IDLE; dmem_req drops immediately.
//    Reset mid-access abandons the access; no write-back occurs.
//  - mem_op = em_valid & (em_mem_r | em_mem_w).
//    If ex_mem_r & ex_mem_w are both set: treated as a load, and mem_w is ignored.
//  - FSM:
//    IDLE: dmem_req=0. mem_op -> BUSY; count cleared.
//    BUSY: dmem_req=1, dmem_we=em_mem_w & !em_mem_r; addr/wdata come from EX/MEM and are held stable.
//      dmem_ack -> IDLE.
//      count==TIMEOUT-1 without ack -> IDLE, mem_err<=1, access treated as complete with rdata=0.
//  - stall = mem_op & !(BUSY & (dmem_ack | timeout)). Combinational (ack->stall path permitted).
//  - Every memory op costs >=1 stall cycle; a zero-wait memory gives exactly 1 bubble.
//  - EX/MEM loads ex_* when !stall; otherwise it holds.
//    A completed mem op with a new mem op behind it returns to IDLE for one cycle before re-issue.
//  - MEM/WB, when !stall:
//    wb_valid<=em_valid; wb_en<=em_valid & em_wb_en;
//    wb_data<=em_mem_r ? (timeout ? 0 : dmem_rdata) : em_alu_out; wb_dest<=em_dest.
//  - MEM/WB, when stall: loads a bubble (wb_valid=0, wb_en=0, data/dest hold). A register write never repeats.
//  - Load data is never forwarded from MEM (fwd_mem_wb_en=0). Load-use stalls are the hazard unit's job.
//  - Stores: wb_en follows ex_wb_en (normally 0). mem_err clears only on reset.
//  - count is a $clog2(TIMEOUT+1)-bit saturating counter, active only in BUSY.
// STRUCTURE
//  - FSM state encodings MEM_IDLE/MEM_BUSY live in constants.v.
//  - One sub-module: pipe_reg (parameterised width; async active-low clear, load enable, bubble input).
//    Used for both EX/MEM and MEM/WB. FSM and counter stay in mem_stage.
// TESTING
//  1 ALU op, alu_out=0x10, dest=3, wb_en=1 -> stall=0, fwd_mem_data=0x10 next cycle; wb_data=0x10, wb_en=1 a cycle later.
//  2 load addr 0x40, ack same cycle as req, rdata=0xDEADBEEF -> exactly 1 stall cycle; wb_data=0xDEADBEEF;
//    fwd_mem_wb_en=0 throughout.
//  3 store addr 0x80, data 0x1234, ack after 3 BUSY cycles -> dmem_we=1, addr/wdata stable for all 4 req cycles;
//    4 stall cycles; wb_en=0 bubbles during stall.
//  4 back-to-back loads, 0-wait memory -> req pattern 0,1,0,1; each load written back exactly once.
//  5 TIMEOUT=4, no ack -> req high 4 cycles, then mem_err=1, wb_data=0, pipeline resumes.
//  6 rst low during BUSY -> dmem_req, stall, wb_en low same cycle; after release, FSM IDLE and no stale write-back.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM encodings and helpers for the memory stage.
// Revision 1.0
`default_nettype none

package mem_stage_pkg;

  localparam int STATE_W = 1;
  typedef logic [STATE_W-1:0] mem_state_t;

  localparam mem_state_t MEM_IDLE = 1'b0;
  localparam mem_state_t MEM_BUSY = 1'b1;

  // A load with the store bit also set is still a single load access.
  function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_pipe_reg.sv
// mem_stage_pipe_reg: pipeline register with async active-low clear, load enable and bubble insert.
// Revision 1.0
`default_nettype none

module mem_stage_pipe_reg #(
  parameter int           W           = 8,
  parameter logic [W-1:0] BUBBLE_MASK = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // A bubble clears only the masked control bits; the payload holds.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end else if (bubble_i) begin
      data_d = data_q & ~BUBBLE_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB registers, req/ack data-memory access with timeout, forwarding outputs.
// Revision 1.0
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic              ex_mem_r,
  input  logic              ex_mem_w,
  input  logic              ex_wb_en,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] fwd_mem_data,
  output logic [REG_W-1:0]  fwd_mem_dest,
  output logic              fwd_mem_wb_en,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_en,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int EM_W  = 4 + REG_W + 2 * DATA_W;
  localparam int WB_W  = 2 + REG_W + DATA_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [WB_W-1:0]  WB_BUBBLE_MASK = {2'b11, {(REG_W + DATA_W){1'b0}}};

  logic              em_valid;
  logic              em_mem_r;
  logic              em_mem_w;
  logic              em_wb_en;
  logic [REG_W-1:0]  em_dest;
  logic [DATA_W-1:0] em_alu_out;
  logic [DATA_W-1:0] em_st_data;
  logic [EM_W-1:0]   em_q;

  mem_state_t        state_q;
  mem_state_t        state_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              mem_err_q;
  logic              mem_err_d;

  logic              mem_op;
  logic              busy;
  logic              timeout;
  logic [DATA_W-1:0] wb_value;
  logic [WB_W-1:0]   wb_q;

  mem_stage_pipe_reg #(
    .W          (EM_W),
    .BUBBLE_MASK('0)
  ) u_ex_mem (
    .clk     (clk),
    .rst     (rst),
    .load_i  (~stall),
    .bubble_i(1'b0),
    .d_i     ({ex_valid, ex_mem_r, ex_mem_w, ex_wb_en, ex_dest, ex_alu_out, ex_st_data}),
    .q_o     (em_q)
  );

  assign {em_valid, em_mem_r, em_mem_w, em_wb_en, em_dest, em_alu_out, em_st_data} = em_q;

  assign mem_op  = is_mem_op(em_valid, em_mem_r, em_mem_w);
  assign busy    = (state_q == MEM_BUSY);
  assign timeout = busy & ~dmem_ack & (count_q == CNT_LAST);
  assign stall   = mem_op & ~(busy & (dmem_ack | timeout));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MEM_IDLE;
      count_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = '0;
    mem_err_d = mem_err_q | timeout;
    case (state_q)
      MEM_IDLE: begin
        if (mem_op) begin
          state_d = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        if (dmem_ack || timeout) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (state_q)
      MEM_BUSY: begin
        dmem_req = 1'b1;
        dmem_we  = em_mem_w & ~em_mem_r;
      end
      default: begin
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
      end
    endcase
  end

  assign dmem_addr     = em_alu_out;
  assign dmem_wdata    = em_st_data;
  assign fwd_mem_data  = em_alu_out;
  assign fwd_mem_dest  = em_dest;
  assign fwd_mem_wb_en = em_valid & em_wb_en & ~em_mem_r;
  assign mem_err       = mem_err_q;

  // An aborted load writes back zero rather than whatever sits on the bus.
  assign wb_value = em_mem_r ? (timeout ? '0 : dmem_rdata) : em_alu_out;

  mem_stage_pipe_reg #(
    .W          (WB_W),
    .BUBBLE_MASK(WB_BUBBLE_MASK)
  ) u_mem_wb (
    .clk     (clk),
    .rst     (rst),
    .load_i  (~stall),
    .bubble_i(stall),
    .d_i     ({em_valid, em_valid & em_wb_en, em_dest, wb_value}),
    .q_o     (wb_q)
  );

  assign {wb_valid, wb_en, wb_dest, wb_data} = wb_q;

endmodule

`default_nettype wire
